// File: rtl/fifo_if_pkg.sv
// rtl/fifo_if_pkg.sv - shared constants and types for the FIFO read stage
// Contents:
//   SKID_DEPTH  number of entries in the read-side skid buffer
//   skid_lvl_t  skid-buffer occupancy, 0..SKID_DEPTH
package fifo_if_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] skid_lvl_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// rtl/fifo_rd_skid_buf.sv - 2-entry register buffer feeding the output stream
// Ports:
//   aclk     in   clock, rising edge
//   aresetn  in   asynchronous active-low reset
//   srst     in   synchronous clear, overrides push/pop
//   push     in   write din into the tail entry
//   pop      in   retire the head entry
//   din      in   DATA_WIDTH write data
//   dout     out  DATA_WIDTH head entry (register-sourced, no path from din)
//   level    out  occupancy 0..2
module fifo_rd_skid_buf
  import fifo_if_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output skid_lvl_t             level
);

  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  skid_lvl_t             r_level;
  logic [DATA_WIDTH-1:0] r_mem0;
  logic [DATA_WIDTH-1:0] r_mem1;
  logic                  w_wr_en;

  assign w_wr_en = push && !srst;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_level  <= '0;
    end else if (srst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_level  <= '0;
    end else begin
      // 1-bit pointers simply toggle, giving the 1->0 wrap
      if (push) r_wr_ptr <= ~r_wr_ptr;
      if (pop)  r_rd_ptr <= ~r_rd_ptr;
      r_level <= r_level + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry 0 is the head after reset, so only it is cleared; this makes dout=0 in reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_mem0 <= '0;
    end else if (w_wr_en && !r_wr_ptr) begin
      r_mem0 <= din;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_wr_en && r_wr_ptr) begin
      r_mem1 <= din;
    end
  end

  // A full-buffer push only happens with a pop, so the head slot being overwritten
  // is the one that leaves in the same cycle; the visible head never changes early.
  assign dout  = r_rd_ptr ? r_mem1 : r_mem0;
  assign level = r_level;

endmodule

// File: rtl/fifo_rd_stage.sv
// rtl/fifo_rd_stage.sv - FIFO read stage: pull credit logic plus skid-buffered output stream
// Ports:
//   aclk        in   clock, rising edge
//   aresetn     in   asynchronous active-low reset
//   srst        in   synchronous clear, asserted together with the FIFO's clear
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   DATA_WIDTH FIFO read data
//   fifo_pull   out  FIFO pop request (combinational)
//   m_valid     out  output beat valid
//   m_ready     in   output beat accepted
//   m_data      out  DATA_WIDTH output beat data (registered)
//   buf_level   out  skid-buffer occupancy 0..2
module fifo_rd_stage
  import fifo_if_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pull,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output skid_lvl_t             buf_level
);

  skid_lvl_t  w_occ;
  logic       w_pop;
  logic       w_arrive;
  logic       w_push;
  logic       w_inflight;
  logic [2:0] w_credit_used;

  assign w_pop = m_valid && m_ready;

  // Words already owned by this stage after this cycle's pop; a pull is allowed
  // only while that leaves room in the buffer. m_ready -> fifo_pull is combinational.
  assign w_credit_used = {1'b0, w_occ} + {2'b00, w_inflight} - {2'b00, w_pop};
  assign fifo_pull     = aresetn && !fifo_empty && !srst &&
                         (w_credit_used < 3'(SKID_DEPTH));

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign w_inflight = 1'b0;
      assign w_arrive   = fifo_pull;
    end else begin : g_lat1
      logic r_inflight;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_inflight <= 1'b0;
        end else if (srst) begin
          r_inflight <= 1'b0;
        end else begin
          r_inflight <= fifo_pull;
        end
      end

      assign w_inflight = r_inflight;
      assign w_arrive   = r_inflight;
    end
  endgenerate

  // A word returning in the srst cycle belongs to the pre-clear stream and is dropped
  assign w_push = w_arrive && !srst;

  fifo_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .aclk   (aclk),
    .aresetn(aresetn),
    .srst   (srst),
    .push   (w_push),
    .pop    (w_pop),
    .din    (fifo_data),
    .dout   (m_data),
    .level  (w_occ)
  );

  assign m_valid   = (w_occ != '0);
  assign buf_level = w_occ;

endmodule

// File: tb/tb_fifo_rd_stage.sv
// tb/tb_fifo_rd_stage.sv - self-checking bench for fifo_rd_stage, both read latencies in lockstep
module tb_fifo_rd_stage;

  localparam int DW = 16;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic srst    = 1'b0;
  logic m_ready = 1'b0;

  logic [1:0]         fifo_empty;
  logic [1:0]         fifo_pull;
  logic [1:0]         m_valid;
  logic [1:0][DW-1:0] fifo_data;
  logic [1:0][DW-1:0] m_data;
  logic [1:0][1:0]    buf_level;

  // FIFO models, index 0 = RD_LATENCY 0 instance, index 1 = RD_LATENCY 1 instance
  logic [DW-1:0] fmem [2][256];
  logic [7:0]    wr_p [2] = '{8'd0, 8'd0};
  logic [7:0]    rd_p [2] = '{8'd0, 8'd0};
  logic [DW-1:0] r_fd1 = '0;

  logic [DW-1:0] exp_q [2][$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  assign fifo_empty[0] = (rd_p[0] == wr_p[0]);
  assign fifo_empty[1] = (rd_p[1] == wr_p[1]);
  assign fifo_data[0]  = fmem[0][rd_p[0]];
  assign fifo_data[1]  = r_fd1;

  always @(posedge aclk) begin
    for (int k = 0; k < 2; k++) begin
      if (srst) rd_p[k] <= wr_p[k];
      else if (fifo_pull[k]) rd_p[k] <= rd_p[k] + 8'd1;
    end
    if (fifo_pull[1]) r_fd1 <= fmem[1][rd_p[1]];
  end

  fifo_rd_stage #(.DATA_WIDTH(DW), .RD_LATENCY(0)) u_dut_lat0 (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .fifo_empty(fifo_empty[0]),
    .fifo_data (fifo_data[0]),
    .fifo_pull (fifo_pull[0]),
    .m_valid   (m_valid[0]),
    .m_ready   (m_ready),
    .m_data    (m_data[0]),
    .buf_level (buf_level[0])
  );

  fifo_rd_stage #(.DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut_lat1 (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .fifo_empty(fifo_empty[1]),
    .fifo_data (fifo_data[1]),
    .fifo_pull (fifo_pull[1]),
    .m_valid   (m_valid[1]),
    .m_ready   (m_ready),
    .m_data    (m_data[1]),
    .buf_level (buf_level[1])
  );

  task automatic push_word(input logic [DW-1:0] v);
    for (int k = 0; k < 2; k++) begin
      fmem[k][wr_p[k]] = v;
      wr_p[k] = wr_p[k] + 8'd1;
      exp_q[k].push_back(v);
    end
  endtask

  task automatic flush_sb();
    for (int k = 0; k < 2; k++) exp_q[k].delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (m_valid[k] !== 1'b0) begin
        n_errors++; $display("FAIL reset_m_valid[%0d]: got %0b expected 0", k, m_valid[k]);
      end
      n_checks++;
      if (m_data[k] !== 16'h0000) begin
        n_errors++; $display("FAIL reset_m_data[%0d]: got %0h expected 0", k, m_data[k]);
      end
      n_checks++;
      if (buf_level[k] !== 2'd0) begin
        n_errors++; $display("FAIL reset_buf_level[%0d]: got %0d expected 0", k, buf_level[k]);
      end
      n_checks++;
      if (fifo_pull[k] !== 1'b0) begin
        n_errors++; $display("FAIL reset_fifo_pull[%0d]: got %0b expected 0", k, fifo_pull[k]);
      end
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_latency();
    logic [DW-1:0] e;
    logic          exp_v;
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    for (int c = 1; c <= 7; c++) begin
      @(negedge aclk);
      for (int k = 0; k < 2; k++) begin
        exp_v = (c >= 1 + k) && (c <= 4 + k);
        n_checks++;
        if (m_valid[k] !== exp_v) begin
          n_errors++; $display("FAIL latency_valid[%0d] c=%0d: got %0b expected %0b", k, c, m_valid[k], exp_v);
        end
        if (m_valid[k] && m_ready && exp_q[k].size() != 0) begin
          e = exp_q[k].pop_front();
          n_checks++;
          if (m_data[k] !== e) begin
            n_errors++; $display("FAIL latency_data[%0d] c=%0d: got %0h expected %0h", k, c, m_data[k], e);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0) begin
        n_errors++; $display("FAIL latency_left[%0d]: got %0d undelivered expected 0", k, exp_q[k].size());
      end
    end
  endtask

  task automatic test_backpressure();
    int            pulls [2];
    logic [DW-1:0] e;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(16'h0100 + DW'(i));
    pulls = '{0, 0};
    for (int i = 0; i < 10; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        if (fifo_pull[k]) pulls[k]++;
        if (m_valid[k]) begin
          n_checks++;
          if (m_data[k] !== exp_q[k][0]) begin
            n_errors++; $display("FAIL bp_hold_data[%0d]: got %0h expected %0h", k, m_data[k], exp_q[k][0]);
          end
        end
      end
      @(negedge aclk);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (pulls[k] != 2) begin
        n_errors++; $display("FAIL bp_pulls[%0d]: got %0d expected 2", k, pulls[k]);
      end
      n_checks++;
      if (buf_level[k] !== 2'd2) begin
        n_errors++; $display("FAIL bp_level[%0d]: got %0d expected 2", k, buf_level[k]);
      end
      n_checks++;
      if (m_valid[k] !== 1'b1) begin
        n_errors++; $display("FAIL bp_valid[%0d]: got %0b expected 1", k, m_valid[k]);
      end
    end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (m_valid[k] !== 1'b1) begin
          n_errors++; $display("FAIL bp_bubble[%0d] beat=%0d: got %0b expected 1", k, i, m_valid[k]);
        end else if (exp_q[k].size() != 0) begin
          e = exp_q[k].pop_front();
          n_checks++;
          if (m_data[k] !== e) begin
            n_errors++; $display("FAIL bp_data[%0d] beat=%0d: got %0h expected %0h", k, i, m_data[k], e);
          end
        end
      end
      @(negedge aclk);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (m_valid[k] !== 1'b0 || exp_q[k].size() != 0) begin
        n_errors++; $display("FAIL bp_end[%0d]: got valid=%0b left=%0d expected valid=0 left=0", k, m_valid[k], exp_q[k].size());
      end
    end
  endtask

  task automatic test_toggle();
    logic          hold [2];
    logic [DW-1:0] held [2];
    logic [DW-1:0] e;
    hold = '{1'b0, 1'b0};
    for (int i = 0; i < 16; i++) push_word(16'h0010 + DW'(i));
    for (int i = 0; i < 80 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) begin
      m_ready = ~i[0];
      for (int k = 0; k < 2; k++) begin
        if (hold[k]) begin
          n_checks++;
          if (m_valid[k] !== 1'b1 || m_data[k] !== held[k]) begin
            n_errors++; $display("FAIL toggle_hold[%0d]: got valid=%0b data=%0h expected valid=1 data=%0h", k, m_valid[k], m_data[k], held[k]);
          end
        end
        if (m_valid[k] && m_ready) begin
          n_checks++;
          if (exp_q[k].size() == 0) begin
            n_errors++; $display("FAIL toggle_extra[%0d]: got beat %0h expected none", k, m_data[k]);
          end else begin
            e = exp_q[k].pop_front();
            if (m_data[k] !== e) begin
              n_errors++; $display("FAIL toggle_data[%0d]: got %0h expected %0h", k, m_data[k], e);
            end
          end
        end
        hold[k] = m_valid[k] && !m_ready;
        held[k] = m_data[k];
      end
      @(negedge aclk);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0 || m_valid[k] !== 1'b0) begin
        n_errors++; $display("FAIL toggle_end[%0d]: got left=%0d valid=%0b expected left=0 valid=0", k, exp_q[k].size(), m_valid[k]);
      end
    end
  endtask

  task automatic test_srst();
    logic got [2];
    logic [DW-1:0] e;
    got = '{1'b0, 1'b0};
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'h0200 + DW'(i));
    repeat (2) @(negedge aclk);
    n_checks++;
    if (buf_level[0] !== 2'd2 || buf_level[1] !== 2'd1) begin
      n_errors++; $display("FAIL srst_pre_level: got %0d/%0d expected 2/1", buf_level[0], buf_level[1]);
    end
    srst = 1'b1;
    flush_sb();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (fifo_pull[k] !== 1'b0) begin
        n_errors++; $display("FAIL srst_pull[%0d]: got %0b expected 0", k, fifo_pull[k]);
      end
    end
    @(negedge aclk);
    srst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (m_valid[k] !== 1'b0 || buf_level[k] !== 2'd0) begin
        n_errors++; $display("FAIL srst_clear[%0d]: got valid=%0b level=%0d expected 0/0", k, m_valid[k], buf_level[k]);
      end
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (m_valid[k] !== 1'b0) begin
          n_errors++; $display("FAIL srst_stale[%0d]: got beat %0h expected none", k, m_data[k]);
        end
      end
    end
    push_word(16'h00AA);
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      for (int k = 0; k < 2; k++) begin
        if (!got[k] && m_valid[k] && exp_q[k].size() != 0) begin
          got[k] = 1'b1;
          e = exp_q[k].pop_front();
          n_checks++;
          if (m_data[k] !== e) begin
            n_errors++; $display("FAIL srst_first[%0d]: got %0h expected %0h", k, m_data[k], e);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (!got[k]) begin
        n_errors++; $display("FAIL srst_timeout[%0d]: got no beat expected 00aa", k);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] e;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(16'h0300 + DW'(i));
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      for (int k = 0; k < 2; k++) begin
        if (m_valid[k] && exp_q[k].size() != 0) begin
          e = exp_q[k].pop_front();
          n_checks++;
          if (m_data[k] !== e) begin
            n_errors++; $display("FAIL ares_pre_data[%0d]: got %0h expected %0h", k, m_data[k], e);
          end
        end
      end
    end
    #2;
    aresetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (m_valid[k] !== 1'b0 || m_data[k] !== 16'h0000 || buf_level[k] !== 2'd0) begin
        n_errors++; $display("FAIL ares_clear[%0d]: got valid=%0b data=%0h level=%0d expected 0/0/0", k, m_valid[k], m_data[k], buf_level[k]);
      end
      n_checks++;
      if (fifo_pull[k] !== 1'b0) begin
        n_errors++; $display("FAIL ares_pull[%0d]: got %0b expected 0", k, fifo_pull[k]);
      end
    end
    @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (fifo_pull[k] !== 1'b0 || m_valid[k] !== 1'b0) begin
        n_errors++; $display("FAIL ares_hold[%0d]: got pull=%0b valid=%0b expected 0/0", k, fifo_pull[k], m_valid[k]);
      end
    end
    aresetn = 1'b1;
    srst    = 1'b1;
    flush_sb();
    @(negedge aclk);
    srst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (m_valid[k] !== 1'b0 || buf_level[k] !== 2'd0) begin
        n_errors++; $display("FAIL ares_after[%0d]: got valid=%0b level=%0d expected 0/0", k, m_valid[k], buf_level[k]);
      end
    end
    @(negedge aclk);
  endtask

  task automatic test_empty();
    for (int i = 0; i < 20; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (fifo_pull[k] !== 1'b0 || m_valid[k] !== 1'b0) begin
          n_errors++; $display("FAIL empty[%0d] cyc=%0d: got pull=%0b valid=%0b expected 0/0", k, i, fifo_pull[k], m_valid[k]);
        end
      end
      @(negedge aclk);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_toggle();
    test_srst();
    test_async_reset();
    test_empty();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
